// File: rtl/his_readout_fsm_if.sv
// Histogram readout bus: BRAM second-port read/clear strobes plus the bin stream.
// Purely combinational wiring, no latency of its own.
// The bin stream is valid/ready; the memory side has no backpressure (fixed 1-cycle read).
interface his_readout_fsm_if #(
   parameter int NB    = 8,
   parameter int CNT_W = 16
);
   // Histogram memory port
   logic             mem_rd_en;
   logic             mem_bank;
   logic [NB-1:0]    mem_addr;
   logic [CNT_W-1:0] mem_rd_data;
   logic             mem_wr_en;

   // Bin stream towards depth/peak processing
   logic             bin_valid;
   logic             bin_ready;
   logic [NB-1:0]    bin_addr;
   logic [CNT_W-1:0] bin_count;
   logic             bin_last;

   // Readout engine side
   modport master (
      output mem_rd_en, mem_bank, mem_addr, mem_wr_en,
      input  mem_rd_data,
      output bin_valid, bin_addr, bin_count, bin_last,
      input  bin_ready
   );

   // Memory / downstream side
   modport slave (
      input  mem_rd_en, mem_bank, mem_addr, mem_wr_en,
      output mem_rd_data,
      input  bin_valid, bin_addr, bin_count, bin_last,
      output bin_ready
   );
endinterface

// File: rtl/his_readout_fsm.sv
// Read-and-clear scan of one histogram bank: stream every bin, zero it, track the peak.
// 3 cycles per bin with bin_ready high; acq_done -> peak_valid is 3*BIN_NUM+1 cycles.
// Holds each bin on the stream until bin_ready; acq_done while busy is dropped and flagged.
module his_readout_fsm #(
   parameter int NB      = 8,
   parameter int BIN_NUM = 256,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             res,
   input  logic             acq_done,
   input  logic             done_bank,
   his_readout_fsm_if.master bus,
   output logic             peak_valid,
   output logic [NB-1:0]    peak_bin,
   output logic [CNT_W-1:0] peak_count,
   output logic             busy,
   output logic             overrun
);

   localparam logic [NB-1:0] LAST_IDX = NB'(BIN_NUM - 1);

   typedef enum logic [2:0] {IDLE, RD, CAP, OUT, DONE} state_t;

   state_t        state;
   logic [NB-1:0] idx;

   // Scan sequencer; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (res) begin
         state          <= IDLE;
         idx            <= '0;
         bus.mem_rd_en  <= 1'b0;
         bus.mem_bank   <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wr_en  <= 1'b0;
         bus.bin_valid  <= 1'b0;
         bus.bin_addr   <= '0;
         bus.bin_count  <= '0;
         bus.bin_last   <= 1'b0;
         peak_valid     <= 1'b0;
         peak_bin       <= '0;
         peak_count     <= '0;
         busy           <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         // Requests are only accepted from IDLE; anything else is reported and dropped.
         overrun    <= acq_done && (state != IDLE);
         peak_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (acq_done) begin
                  bus.mem_bank  <= done_bank;
                  idx           <= '0;
                  peak_bin      <= '0;
                  peak_count    <= '0;
                  bus.mem_addr  <= '0;
                  bus.mem_rd_en <= 1'b1;
                  busy          <= 1'b1;
                  state         <= RD;
               end
            end

            RD: begin
               // Read issued this cycle; next cycle clears the same bin while data returns.
               bus.mem_rd_en <= 1'b0;
               bus.mem_wr_en <= 1'b1;
               state         <= CAP;
            end

            CAP: begin
               bus.mem_wr_en <= 1'b0;
               bus.bin_count <= bus.mem_rd_data;
               bus.bin_addr  <= idx;
               bus.bin_last  <= (idx == LAST_IDX);
               bus.bin_valid <= 1'b1;
               // Strict compare so equal counts keep the earlier bin.
               if (bus.mem_rd_data > peak_count) begin
                  peak_count <= bus.mem_rd_data;
                  peak_bin   <= idx;
               end
               state <= OUT;
            end

            OUT: begin
               if (bus.bin_ready) begin
                  bus.bin_valid <= 1'b0;
                  if (bus.bin_last) begin
                     peak_valid <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx           <= idx + 1'b1;
                     bus.mem_addr  <= idx + 1'b1;
                     bus.mem_rd_en <= 1'b1;
                     state         <= RD;
                  end
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_his_readout_fsm.sv
module tb_his_readout_fsm;
   localparam int NB      = 3;
   localparam int BIN_NUM = 8;
   localparam int CNT_W   = 16;
   localparam logic [127:0] OTHER = 128'h0088_0077_0066_0055_0044_0033_0022_0011;

   logic             clk = 1'b0;
   logic             res;
   logic             acq_done;
   logic             done_bank;
   logic             peak_valid;
   logic [NB-1:0]    peak_bin;
   logic [CNT_W-1:0] peak_count;
   logic             busy;
   logic             overrun;

   his_readout_fsm_if #(.NB(NB), .CNT_W(CNT_W)) bus ();

   his_readout_fsm #(.NB(NB), .BIN_NUM(BIN_NUM), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .res        (res),
      .acq_done   (acq_done),
      .done_bank  (done_bank),
      .bus        (bus),
      .peak_valid (peak_valid),
      .peak_bin   (peak_bin),
      .peak_count (peak_count),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Two-bank histogram memory, 1-cycle read latency, write-zero on clear strobe.
   logic [CNT_W-1:0] mem [2][BIN_NUM];
   logic             ld_en = 1'b0;
   logic             ld_bank = 1'b0;
   logic [127:0]     ld_dat = '0;

   always @(posedge clk) begin
      if (ld_en)
         for (int i = 0; i < BIN_NUM; i++) mem[ld_bank][i] <= ld_dat[i*16 +: 16];
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_bank][bus.mem_addr];
      if (bus.mem_wr_en) mem[bus.mem_bank][bus.mem_addr] <= '0;
   end

   int excl_viol = 0;
   always @(negedge clk) if (bus.mem_rd_en && bus.mem_wr_en) excl_viol++;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] out_vec();
      return {15'd0, bus.mem_rd_en, bus.mem_bank, bus.mem_addr, bus.mem_wr_en,
              bus.bin_valid, bus.bin_addr, bus.bin_count, bus.bin_last,
              peak_valid, peak_bin, peak_count, busy, overrun};
   endfunction

   task automatic load_bank(input logic b, input logic [127:0] d);
      ld_bank = b;
      ld_dat  = d;
      ld_en   = 1'b1;
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   // Reference peak: first index holding the maximum value.
   task automatic model_peak(input logic [127:0] d, output int pb, output logic [15:0] pc);
      pb = 0;
      pc = d[15:0];
      for (int i = 1; i < BIN_NUM; i++)
         if (d[i*16 +: 16] > pc) begin
            pc = d[i*16 +: 16];
            pb = i;
         end
   endtask

   // One full scan: expected beats come from a snapshot of the bank taken before start.
   task automatic run_scan(input logic bank, input int rmode, input int exp_pb,
                           input logic [15:0] exp_pc, input int ovr_at, input string name);
      logic [15:0] snap [BIN_NUM];
      logic [15:0] other [BIN_NUM];
      logic [19:0] held;
      logic        r;
      int          beats = 0;
      bit          got_peak = 0;
      bit          stall = 0;
      bit          ovr_chk = 0;
      bit          ovr_low = 0;
      int          nz = 0;
      int          diff = 0;
      for (int i = 0; i < BIN_NUM; i++) begin
         snap[i]  = mem[bank][i];
         other[i] = mem[~bank][i];
      end
      @(negedge clk);
      acq_done  = 1'b1;
      done_bank = bank;
      for (int cyc = 1; cyc <= 400 && !got_peak; cyc++) begin
         @(negedge clk);
         acq_done = 1'b0;
         if (ovr_chk) begin
            check({name, "_overrun_pulse"}, 64'(overrun), 64'(1));
            ovr_chk = 0;
            ovr_low = 1;
         end else if (ovr_low) begin
            check({name, "_overrun_clear"}, 64'(overrun), 64'(0));
            ovr_low = 0;
         end
         if (stall) begin
            check({name, "_stall_valid"}, 64'(bus.bin_valid), 64'(1));
            check({name, "_stall_data"}, 64'({bus.bin_addr, bus.bin_count, bus.bin_last}), 64'(held));
            stall = 0;
         end
         case (rmode)
            0:       r = 1'b1;
            1:       r = (cyc % 3 == 1);
            default: r = 1'($urandom_range(0, 1));
         endcase
         bus.bin_ready = r;
         if (bus.bin_valid) begin
            if (r) begin
               if (beats < BIN_NUM) begin
                  check({name, "_beat_addr"}, 64'(bus.bin_addr), 64'(beats));
                  check({name, "_beat_count"}, 64'(bus.bin_count), 64'(snap[beats]));
                  check({name, "_beat_last"}, 64'(bus.bin_last), 64'(beats == BIN_NUM - 1));
               end else begin
                  check({name, "_extra_beat"}, 64'(1), 64'(0));
               end
               if (beats == ovr_at) begin
                  acq_done  = 1'b1;
                  done_bank = ~bank;
                  ovr_chk   = 1;
               end
               beats++;
            end else begin
               stall = 1;
               held  = {bus.bin_addr, bus.bin_count, bus.bin_last};
            end
         end
         if (peak_valid) begin
            got_peak = 1;
            check({name, "_beats"}, 64'(beats), 64'(BIN_NUM));
            check({name, "_peak_bin"}, 64'(peak_bin), 64'(exp_pb));
            check({name, "_peak_count"}, 64'(peak_count), 64'(exp_pc));
            if (rmode == 0) check({name, "_latency"}, 64'(cyc), 64'(3 * BIN_NUM + 1));
         end
      end
      if (!got_peak) check({name, "_peak_timeout"}, 64'(0), 64'(1));
      bus.bin_ready = 1'b1;
      @(negedge clk);
      check({name, "_peak_pulse_end"}, 64'({peak_valid, busy}), 64'(0));
      check({name, "_peak_held"}, 64'({peak_bin, peak_count}), 64'({exp_pb[NB-1:0], exp_pc}));
      for (int i = 0; i < BIN_NUM; i++) begin
         if (mem[bank][i] != 0) nz++;
         if (mem[~bank][i] != other[i]) diff++;
      end
      check({name, "_bank_cleared"}, 64'(nz), 64'(0));
      check({name, "_other_bank_kept"}, 64'(diff), 64'(0));
   endtask

   typedef struct packed {
      logic         bank;
      logic [1:0]   rmode;
      logic [2:0]   exp_pb;
      logic [15:0]  exp_pc;
      logic [127:0] data;
   } vec_t;

   initial begin
      vec_t         tab [5];
      string        tname [5];
      logic [127:0] d;
      logic [15:0]  pc;
      int           pb;
      bit           found;

      // bins listed 7..0 (MSB first)
      tab[0] = '{1'b0, 2'd0, 3'd2, 16'd9,
                 {16'd2, 16'd0, 16'd0, 16'd1, 16'd9, 16'd9, 16'd0, 16'd3}};
      tab[1] = '{1'b0, 2'd1, 3'd2, 16'd9,
                 {16'd2, 16'd0, 16'd0, 16'd1, 16'd9, 16'd9, 16'd0, 16'd3}};
      tab[2] = '{1'b1, 2'd0, 3'd0, 16'd0, 128'd0};
      tab[3] = '{1'b0, 2'd0, 3'd7, 16'hFFFF,
                 {16'hFFFF, {7{16'hFFFE}}}};
      tab[4] = '{1'b1, 2'd2, 3'd1, 16'd7,
                 {16'd0, 16'd0, 16'd0, 16'd7, 16'd2, 16'd7, 16'd7, 16'd5}};
      tname[0] = "basic";
      tname[1] = "ready_1of3";
      tname[2] = "bank1_zero";
      tname[3] = "peak_last";
      tname[4] = "ties_random_ready";

      res = 1'b1;
      acq_done = 1'b0;
      done_bank = 1'b0;
      bus.bin_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", out_vec(), 64'(0));
      res = 1'b0;

      for (int t = 0; t < 5; t++) begin
         load_bank(tab[t].bank, tab[t].data);
         load_bank(~tab[t].bank, OTHER);
         run_scan(tab[t].bank, int'(tab[t].rmode), int'(tab[t].exp_pb), tab[t].exp_pc, -1, tname[t]);
      end

      // acq_done during beat 3: flagged, ignored, no follow-on scan
      load_bank(1'b0, {16'd2, 16'd0, 16'd0, 16'd1, 16'd9, 16'd9, 16'd0, 16'd3});
      load_bank(1'b1, OTHER);
      run_scan(1'b0, 0, 2, 16'd9, 3, "overrun");
      repeat (3) @(negedge clk);
      check("overrun_no_rescan", 64'({busy, bus.mem_rd_en, bus.bin_valid}), 64'(0));

      // Reset during beat 4: abort, later bins keep their counts
      load_bank(1'b0, {16'd17, 16'd16, 16'd15, 16'd14, 16'd13, 16'd12, 16'd11, 16'd10});
      @(negedge clk);
      acq_done = 1'b1;
      done_bank = 1'b0;
      bus.bin_ready = 1'b1;
      found = 0;
      for (int c = 0; c < 60 && !found; c++) begin
         @(negedge clk);
         acq_done = 1'b0;
         if (bus.bin_valid && bus.bin_addr == 3'd4) found = 1;
      end
      check("reset_mid_found_beat4", 64'(found), 64'(1));
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      check("reset_mid_outputs", out_vec(), 64'(0));
      check("reset_mid_bins_5_7", 64'({mem[0][5], mem[0][6], mem[0][7]}), 64'({16'd15, 16'd16, 16'd17}));
      check("reset_mid_bins_0_4", 64'({mem[0][0], mem[0][1], mem[0][2], mem[0][3]}), 64'(0));
      check("reset_mid_bin4", 64'(mem[0][4]), 64'(0));
      run_scan(1'b0, 0, 7, 16'd17, -1, "after_reset");

      // Randomised scans against the reference peak
      for (int k = 0; k < 6; k++) begin
         logic b;
         b = 1'($urandom_range(0, 1));
         for (int i = 0; i < BIN_NUM; i++)
            d[i*16 +: 16] = (k % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         model_peak(d, pb, pc);
         load_bank(b, d);
         load_bank(~b, OTHER);
         run_scan(b, int'($urandom_range(0, 2)), pb, pc, -1, "random");
      end

      check("rd_wr_exclusive", 64'(excl_viol), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
